// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_out_reorder
// Summary  : Ping-pong reorder of bit-reversed FFT frames into natural order.
//            Define FFT_OUT_SCALE_EN to divide each output word by 2^N.
// Revision : 1.0 - initial release
// ============================================================================
module fft_out_reorder #(
    parameter int N = 3,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start_ip,
    input  logic [W-1:0] ip_re,
    input  logic [W-1:0] ip_im,
    output logic         start_op,
    output logic         op_valid,
    output logic [W-1:0] op_re,
    output logic [W-1:0] op_im,
    output logic [N-1:0] op_idx,
    output logic         bank_err
);
    localparam int           c_depth    = 1 << N;
    localparam logic [N-1:0] c_last_idx = {N{1'b1}};
    localparam logic [N-1:0] c_one      = N'(1);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_FILL = 1'b1} wr_state_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DRAIN = 1'b1} rd_state_t;

    wr_state_t      r_wr_state, w_wr_state_nxt;
    rd_state_t      r_rd_state, w_rd_state_nxt;
    logic [N-1:0]   r_wk, w_wk_nxt;
    logic [N-1:0]   r_ridx;
    logic           r_wb, r_rb;
    logic [1:0]     r_full, w_full_nxt;
    logic           w_wr_en, w_wr_done;
    logic [N-1:0]   w_wr_addr;
    logic           w_rd_fire, w_rd_last;
    logic           w_avail_cur, w_avail_oth;
    logic [2*W-1:0] w_rd_word;
    logic [W-1:0]   w_rd_re, w_rd_im;
    logic [2*W-1:0] r_mem [2][c_depth];

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = a[N-1-i];
        return r;
    endfunction

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wk_nxt       = r_wk;
        w_wr_en        = 1'b0;
        w_wr_done      = 1'b0;
        w_wr_addr      = bitrev(r_wk);
        if (start_ip) begin
            // A start while filling abandons the partial frame in the same bank.
            w_wr_en        = 1'b1;
            w_wr_addr      = '0;
            w_wk_nxt       = c_one;
            w_wr_state_nxt = W_FILL;
        end else if (r_wr_state == W_FILL) begin
            w_wr_en  = 1'b1;
            w_wk_nxt = r_wk + c_one;
            if (r_wk == c_last_idx) begin
                w_wr_done      = 1'b1;
                w_wr_state_nxt = W_IDLE;
            end
        end
    end

    // A frame completing this cycle counts as available so the drain starts without a bubble.
    assign w_avail_cur = r_full[r_rb]  | (w_wr_done & (r_wb == r_rb));
    assign w_avail_oth = r_full[~r_rb] | (w_wr_done & (r_wb != r_rb));

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_fire      = 1'b0;
        w_rd_last      = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (w_avail_cur) begin
                    w_rd_fire      = 1'b1;
                    w_rd_state_nxt = R_DRAIN;
                end
            end
            R_DRAIN: begin
                w_rd_fire = 1'b1;
                if (r_ridx == c_last_idx) begin
                    w_rd_last = 1'b1;
                    if (!w_avail_oth) w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_last) w_full_nxt[r_rb] = 1'b0;
        if (w_wr_done) w_full_nxt[r_wb] = 1'b1;
    end

    assign w_rd_word = r_mem[r_rb][r_ridx];

`ifdef FFT_OUT_SCALE_EN
    assign w_rd_re = $signed(w_rd_word[2*W-1:W]) >>> N;
    assign w_rd_im = $signed(w_rd_word[W-1:0]) >>> N;
`else
    assign w_rd_re = w_rd_word[2*W-1:W];
    assign w_rd_im = w_rd_word[W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wb][w_wr_addr] <= {ip_re, ip_im};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_state <= W_IDLE;
            r_rd_state <= R_IDLE;
            r_wk       <= '0;
            r_ridx     <= '0;
            r_wb       <= 1'b0;
            r_rb       <= 1'b0;
            r_full     <= '0;
            bank_err   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
            r_wk       <= w_wk_nxt;
            r_full     <= w_full_nxt;
            bank_err   <= bank_err | (w_wr_done & r_full[r_wb]);
            if (w_wr_done) r_wb <= ~r_wb;
            if (w_rd_last) r_rb <= ~r_rb;
            if (w_rd_fire) r_ridx <= r_ridx + c_one;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_op <= 1'b0;
            op_valid <= 1'b0;
            op_idx   <= '0;
            op_re    <= '0;
            op_im    <= '0;
        end else begin
            start_op <= w_rd_fire & (r_ridx == '0);
            op_valid <= w_rd_fire;
            op_idx   <= w_rd_fire ? r_ridx  : '0;
            op_re    <= w_rd_fire ? w_rd_re : '0;
            op_im    <= w_rd_fire ? w_rd_im : '0;
        end
    end
endmodule
`default_nettype wire

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Sink at the far end of the radix-2 SDF butterfly chain.
- Consumes the serial complex stream that the last butterfly stage emits: a one-clock start pulse, then one sample per clock, 2^N samples per frame, in bit-reversed index order.
- Buffers each frame in a ping-pong RAM and re-emits it in natural order with its own start pulse, valid and index.
- Output side drives the FFT result port and the test monitors.

Parameters:
- N, 3, log2 of the FFT size; frame = 2^N samples.
- W, 32, width of each real and imaginary fixed-point word (16 fractional bits).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start_ip  input  1  one-clock pulse from the last stage; marks the cycle carrying sample k=0.
- ip_re  input  W  real part of the current input sample.
- ip_im  input  W  imaginary part of the current input sample.
- start_op  output  1  one-clock pulse coincident with natural-order sample 0.
- op_valid  output  1  high while op_re/op_im carry a reordered sample.
- op_re  output  W  real part of the output sample.
- op_im  output  W  imaginary part of the output sample.
- op_idx  output  N  natural-order index of the current output sample.
- bank_err  output  1  sticky flag: a frame completed while no bank was free.

Behaviour:
- Reset (reset_n low, async): start_op=0, op_valid=0, op_re=op_im=0, op_idx=0, bank_err=0. Writer in W_IDLE, reader in R_IDLE, both bank-full flags cleared, write bank select=0. RAM contents are don't-care.
- Input framing:
  - The cycle with start_ip=1 is sample k=0. Samples k=1..2^N-1 follow on consecutive cycles with no gaps.
  - Inputs outside a frame are ignored.
- Writer FSM:
  - W_IDLE: on start_ip, write the sample to bank wb at address bitrev_N(0)=0, set k=1, go to W_FILL.
  - W_FILL: each cycle write to address bitrev_N(k) and increment k.
  - On writing k=2^N-1: set full[wb], toggle wb, return to W_IDLE.
- Mid-frame restart: start_ip while in W_FILL aborts the partial frame. That cycle's sample becomes k=0 of a new frame in the same bank; full[wb] stays clear. Nothing from the aborted frame is ever output.
- Reader FSM:
  - R_IDLE: when any full bank exists (oldest first, i.e. rb), go to R_DRAIN. op_idx=0 and start_op=1 on the first output cycle.
  - R_DRAIN: output address op_idx, one per clock. After idx 2^N-1: clear full[rb], toggle rb.
  - If the other bank is already full, continue draining back-to-back with a fresh start_op and op_idx=0. Otherwise go to R_IDLE.
- Latency: last input sample on cycle T gives natural sample 0 on cycle T+1 and sample 2^N-1 on cycle T+2^N.
- Outputs are registered. op_re/op_im/op_idx are forced to 0 when op_valid=0. start_op is only ever high together with op_valid.
- Back-to-back frames (start_ip on cycle T+1) sustain full throughput with no stall or gap.
- Simultaneous events:
  - The writer completing a frame and the reader finishing the opposite bank in the same cycle is legal. The new full flag is visible the next cycle, and no bubble is inserted if both transitions coincide on a bank boundary.
  - A write never targets the bank being drained under legal framing.
- bank_err:
  - Set if a frame completes into bank wb while full[wb] is already set. That frame overwrites the bank and the full flag stays set.
  - Cleared only by reset.
- Arithmetic: the data path is pass-through copy, no width change (see Optional Feature).

Optional Feature:
- Macro FFT_OUT_SCALE_EN.
- Defined: each output word is arithmetically shifted right by N (divide by 2^N, truncation toward minus infinity), applied on the read path before the output register.
- Undefined: samples pass through unmodified.
- Latency is identical either way.

Test Plan:
- N=3, start_ip on cycle 0, ip_re = 0,4,2,6,1,5,3,7 on cycles 0..7, ip_im = -ip_re -> start_op on cycle 8 only; op_valid on cycles 8..15; op_re = 0..7 and op_im = 0..-7 in order; op_idx = 0..7.
- Two frames back-to-back (start_ip on cycles 0 and 8) -> op_valid continuous on cycles 8..23; start_op on cycles 8 and 16; both frames in natural order.
- start_ip on cycle 0, again on cycle 5, then a full frame -> exactly one output frame, starting cycle 13, containing only the second frame's data.
- reset_n pulsed low on cycle 11 during a drain -> all outputs 0 asynchronously; no further op_valid until a new full frame is written.
- Inject a third completed frame while both banks are full (reader held by a forced bubble in a directed test) -> bank_err=1 and remains 1.
- With FFT_OUT_SCALE_EN: input re 0x0008_0000 -> output 0x0001_0000; input re 0xFFF8_0000 -> output 0xFFFF_0000.
